// File: rtl/rwt_sample_pkg.sv
// Shared types and lane helpers for the sample unpacker.
package rwt_sample_pkg;

  localparam int SWIDTH = 16;
  localparam int LANES  = 4;
  localparam int BUFN   = 8;

  typedef logic [SWIDTH-1:0] sample_t;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  function automatic logic [1:0] nth_set_lane(
    input logic [3:0] m,
    input logic [1:0] j
  );
    logic [2:0] seen;
    nth_set_lane = 2'd0;
    seen = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (seen == {1'b0, j}) nth_set_lane = 2'(i);
        seen = seen + 3'd1;
      end
    end
  endfunction

endpackage

// File: rtl/rwt_lane_scatter.sv
// Places up to 4 ordered samples onto the set lanes of a mask.
module rwt_lane_scatter
  import rwt_sample_pkg::*;
(
  input  logic [LANES*SWIDTH-1:0] samples,
  input  logic [2:0]              nvalid,
  input  logic [LANES-1:0]        mask,
  output logic [LANES*SWIDTH-1:0] word
);

  logic [2:0] nset;

  assign nset = popcount4(mask);

  always_comb begin
    word = '0;
    for (int j = 0; j < LANES; j++) begin
      if (3'(j) < nvalid && 3'(j) < nset) begin
        word[nth_set_lane(mask, 2'(j))*SWIDTH +: SWIDTH] =
          samples[j*SWIDTH +: SWIDTH];
      end
    end
  end

endmodule

// File: rtl/rwt_sample_unpack.sv
// Packed 4x16 stream to masked 4-lane stream unpacker.
// Optional RWT_SAMPLE_UNPACK_UNDERFLOW_EN adds underflow_count.
module rwt_sample_unpack #(
  parameter int DWIDTH = 64,
  parameter int SWIDTH = 16,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANES-1:0]  enables,
  input  logic [DWIDTH-1:0] s_axi_tdata,
  input  logic              s_axi_tvalid,
  output logic              s_axi_tready,
  input  logic              s_axi_tlast,
  output logic [DWIDTH-1:0] m_axi_tdata,
  output logic              m_axi_tvalid,
  input  logic              m_axi_tready,
  output logic              m_axi_tlast,
  output logic [LANES-1:0]  m_axi_enables
`ifdef RWT_SAMPLE_UNPACK_UNDERFLOW_EN
  ,
  output logic [31:0]       underflow_count
`endif
);

  import rwt_sample_pkg::*;

  if (LANES != DWIDTH / SWIDTH || LANES != 4 ||
      SWIDTH != rwt_sample_pkg::SWIDTH) begin : g_cfg_err
    $error("rwt_sample_unpack: need LANES == DWIDTH/SWIDTH == 4");
  end

  sample_t    mem_q [BUFN];
  sample_t    mem_d [BUFN];
  logic [3:0] cnt_q, cnt_d;
  logic       lp_q, lp_d;
  logic [3:0] en_q, en_d;

  logic [2:0] n;
  logic [3:0] n4;
  logic [2:0] take;
  logic [2:0] cons;
  logic [3:0] base;
  logic       acc;
  logic       keep;
  logic       fire;
  logic [63:0] smp_w;

  assign n    = popcount4(en_q);
  assign n4   = {1'b0, n};
  assign en_d = (cnt_q == 4'd0 && !lp_q) ? enables : en_q;

  assign s_axi_tready = (cnt_q <= 4'd4) && !lp_q;
  assign acc          = s_axi_tvalid && s_axi_tready;
  // Beats arriving with no lane enabled are swallowed.
  assign keep         = acc && (en_d != 4'd0);

  assign m_axi_tvalid  = (n != 3'd0) &&
                         (cnt_q >= n4 || (lp_q && cnt_q != 4'd0));
  assign m_axi_tlast   = lp_q && (cnt_q <= n4);
  assign m_axi_enables = en_q;
  assign fire          = m_axi_tvalid && m_axi_tready;

  assign take = (cnt_q < n4) ? cnt_q[2:0] : n;
  assign cons = fire ? take : 3'd0;
  assign base = cnt_q - {1'b0, cons};

  assign smp_w = {mem_q[3], mem_q[2], mem_q[1], mem_q[0]};

  rwt_lane_scatter u_scatter (
    .samples (smp_w),
    .nvalid  (take),
    .mask    (en_q),
    .word    (m_axi_tdata)
  );

  always_comb begin
    for (int i = 0; i < BUFN; i++) begin
      mem_d[i] = '0;
      if (i + int'(cons) < BUFN) mem_d[i] = mem_q[3'(i + int'(cons))];
    end
    // New samples land right behind whatever survives this cycle.
    if (keep) begin
      for (int k = 0; k < 4; k++) begin
        mem_d[3'(int'(base) + k)] = s_axi_tdata[k*SWIDTH +: SWIDTH];
      end
    end
    cnt_d = base + (keep ? 4'd4 : 4'd0);
    lp_d  = lp_q;
    if (fire && m_axi_tlast) lp_d = 1'b0;
    if (keep && s_axi_tlast) lp_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      lp_q  <= 1'b0;
      en_q  <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
      lp_q  <= lp_d;
      en_q  <= en_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BUFN; i++) mem_q[i] <= mem_d[i];
  end

`ifdef RWT_SAMPLE_UNPACK_UNDERFLOW_EN
  logic        seen_q;
  logic [31:0] uf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= 1'b0;
      uf_q   <= '0;
    end else begin
      if (fire) seen_q <= 1'b1;
      if (seen_q && m_axi_tready && !m_axi_tvalid &&
          en_q != 4'd0 && uf_q != '1) begin
        uf_q <= uf_q + 32'd1;
      end
    end
  end

  assign underflow_count = uf_q;
`endif

endmodule

// File: tb/tb_rwt_sample_unpack.sv
// Self-checking bench for rwt_sample_unpack.
module tb_rwt_sample_unpack;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  enables;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [3:0]  m_en;
`ifdef RWT_SAMPLE_UNPACK_UNDERFLOW_EN
  logic [31:0] uf;
`endif

  always #5 clk = ~clk;

  rwt_sample_unpack dut (
    .clk           (clk),
    .reset         (reset),
    .enables       (enables),
    .s_axi_tdata   (s_tdata),
    .s_axi_tvalid  (s_tvalid),
    .s_axi_tready  (s_tready),
    .s_axi_tlast   (s_tlast),
    .m_axi_tdata   (m_tdata),
    .m_axi_tvalid  (m_tvalid),
    .m_axi_tready  (m_tready),
    .m_axi_tlast   (m_tlast),
    .m_axi_enables (m_en)
`ifdef RWT_SAMPLE_UNPACK_UNDERFLOW_EN
    ,
    .underflow_count (uf)
`endif
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
  } ibeat_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [3:0]  en;
    int          cyc;
    int          ns;
  } obeat_t;

  typedef struct {
    logic [3:0]  en;
    int          nb;
    logic [63:0] in_d [2];
    int          ne;
    logic [63:0] ex_d [3];
    logic [2:0]  ex_l;
    bit          b2b;
  } vec_t;

  int total = 0;
  int bad = 0;

  ibeat_t      in_q [$];
  obeat_t      out_q [$];
  obeat_t      exp_q [$];
  logic [15:0] fr_q [$];
  logic [3:0]  model_en;
  int          rmode, gap_pct, cyc_n;
  bit          sb_on;
  int          outstanding, tready_viol, stab_viol;
  bit          hold_v;
  logic [63:0] hold_d;
  logic        hold_l;
  logic [3:0]  hold_en;
  vec_t        vt [3];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic emit(int k, logic last);
    obeat_t o;
    int j;
    o.d = '0;
    j = 0;
    for (int lane = 0; lane < 4; lane++) begin
      if (model_en[lane] && j < k) begin
        o.d[lane*16 +: 16] = fr_q.pop_front();
        j++;
      end
    end
    o.l = last;
    o.en = model_en;
    o.cyc = 0;
    o.ns = k;
    exp_q.push_back(o);
  endtask

  // Frame-level model: samples chunked N at a time onto the set lanes.
  task automatic model_accept(ibeat_t b);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (model_en[i]) n++;
    if (n == 0) return;
    for (int k = 0; k < 4; k++) fr_q.push_back(b.d[k*16 +: 16]);
    outstanding += 4;
    while (fr_q.size() >= n) emit(n, b.l && fr_q.size() == n);
    if (b.l && fr_q.size() > 0) emit(fr_q.size(), 1'b1);
  endtask

  task automatic tick();
    bit acc, fire;
    obeat_t o, e;
    acc = s_tvalid && s_tready;
    fire = m_tvalid && m_tready;
    if (sb_on) begin
      if (s_tready && outstanding > 4) tready_viol++;
      if (hold_v && (!m_tvalid || m_tdata !== hold_d ||
                     m_tlast !== hold_l || m_en !== hold_en))
        stab_viol++;
    end
    if (fire) begin
      o.d = m_tdata; o.l = m_tlast; o.en = m_en;
      o.cyc = cyc_n; o.ns = 0;
      out_q.push_back(o);
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", m_tdata, e.d);
          chk("sb_last_en", {59'd0, m_tlast, m_en}, {59'd0, e.l, e.en});
          outstanding -= e.ns;
        end
      end
    end
    hold_v = m_tvalid && !m_tready;
    hold_d = m_tdata; hold_l = m_tlast; hold_en = m_en;
    if (acc) begin
      if (sb_on) model_accept(in_q[0]);
      void'(in_q.pop_front());
    end
    @(posedge clk); #1;
    cyc_n++;
    if (!s_tvalid || acc) begin
      if (in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        s_tvalid = 1'b1; s_tdata = in_q[0].d; s_tlast = in_q[0].l;
      end else begin
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
      end
    end
    case (rmode)
      0: m_tready = 1'b1;
      1: m_tready = (cyc_n % 5 == 0);
      2: m_tready = 1'($urandom_range(1));
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    in_q.delete(); out_q.delete(); exp_q.delete(); fr_q.delete();
    outstanding = 0; hold_v = 0; sb_on = 0;
  endtask

  task automatic wait_in(int maxc, string nm);
    int c = 0;
    while (in_q.size() > 0 && c < maxc) begin tick(); c++; end
    if (in_q.size() > 0) chk({nm, "_in_timeout"}, 64'(in_q.size()), 64'd0);
  endtask

  task automatic wait_out(int want, int maxc, string nm);
    int c = 0;
    while (out_q.size() < want && c < maxc) begin tick(); c++; end
    if (out_q.size() < want) chk({nm, "_out_timeout"}, 64'(out_q.size()), 64'(want));
  endtask

  task automatic rand_run(logic [3:0] en, int nbeats, int rm, int gap, int maxc);
    ibeat_t b;
    int c, flen;
    do_reset();
    enables = en; model_en = en; sb_on = 1;
    rmode = rm; gap_pct = gap;
    tready_viol = 0; stab_viol = 0;
    flen = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (flen == 0) flen = $urandom_range(1, 5);
      b.d = {$urandom, $urandom};
      flen--;
      b.l = (flen == 0) || (i == nbeats - 1);
      in_q.push_back(b);
    end
    c = 0;
    while ((in_q.size() > 0 || s_tvalid || exp_q.size() > 0) && c < maxc) begin
      tick(); c++;
    end
    chk("rand_drained", 64'(exp_q.size() + in_q.size()), 64'd0);
    chk("rand_frame_rem", 64'(fr_q.size()), 64'd0);
    chk("rand_tready_rule", 64'(tready_viol), 64'd0);
    chk("rand_stable", 64'(stab_viol), 64'd0);
    sb_on = 0;
  endtask

  initial begin
    ibeat_t b;
    int quiet;
    reset = 1'b0; enables = 4'd0; m_tready = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    rmode = 0; gap_pct = 0; cyc_n = 0; sb_on = 0; model_en = 4'd0;
    tready_viol = 0; stab_viol = 0; outstanding = 0; hold_v = 0;

    vt[0].en = 4'b1111; vt[0].nb = 2;
    vt[0].in_d[0] = 64'h0003_0002_0001_0000;
    vt[0].in_d[1] = 64'h0007_0006_0005_0004;
    vt[0].ne = 2;
    vt[0].ex_d[0] = 64'h0003_0002_0001_0000;
    vt[0].ex_d[1] = 64'h0007_0006_0005_0004;
    vt[0].ex_d[2] = '0;
    vt[0].ex_l = 3'b010; vt[0].b2b = 1;

    vt[1].en = 4'b0101; vt[1].nb = 1;
    vt[1].in_d[0] = 64'h0003_0002_0001_0000;
    vt[1].in_d[1] = '0;
    vt[1].ne = 2;
    vt[1].ex_d[0] = 64'h0000_0001_0000_0000;
    vt[1].ex_d[1] = 64'h0000_0003_0000_0002;
    vt[1].ex_d[2] = '0;
    vt[1].ex_l = 3'b010; vt[1].b2b = 0;

    vt[2].en = 4'b0111; vt[2].nb = 2;
    vt[2].in_d[0] = 64'h0003_0002_0001_0000;
    vt[2].in_d[1] = 64'h0007_0006_0005_0004;
    vt[2].ne = 3;
    vt[2].ex_d[0] = 64'h0000_0002_0001_0000;
    vt[2].ex_d[1] = 64'h0000_0005_0004_0003;
    vt[2].ex_d[2] = 64'h0000_0000_0007_0006;
    vt[2].ex_l = 3'b100; vt[2].b2b = 0;

    do_reset();
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd1);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_tlast_en", {59'd0, m_tlast, m_en}, 64'd0);

    for (int v = 0; v < 3; v++) begin
      do_reset();
      enables = vt[v].en; rmode = 0; gap_pct = 0;
      for (int i = 0; i < vt[v].nb; i++) begin
        b.d = vt[v].in_d[i]; b.l = (i == vt[v].nb - 1);
        in_q.push_back(b);
      end
      wait_out(vt[v].ne, 50, $sformatf("vec%0d", v));
      repeat (4) tick();
      chk($sformatf("vec%0d_nbeats", v), 64'(out_q.size()), 64'(vt[v].ne));
      for (int i = 0; i < vt[v].ne && i < out_q.size(); i++) begin
        chk($sformatf("vec%0d_data%0d", v, i), out_q[i].d, vt[v].ex_d[i]);
        chk($sformatf("vec%0d_last%0d", v, i), 64'(out_q[i].l), 64'(vt[v].ex_l[i]));
        chk($sformatf("vec%0d_en%0d", v, i), 64'(out_q[i].en), 64'(vt[v].en));
        if (vt[v].b2b && i > 0)
          chk($sformatf("vec%0d_b2b%0d", v, i),
              64'(out_q[i].cyc - out_q[i-1].cyc), 64'd1);
      end
    end

    // Mask change mid-frame applies only from the next frame.
    do_reset();
    enables = 4'b1111; rmode = 3; gap_pct = 0;
    b.d = 64'h1113_1112_1111_1110; b.l = 0; in_q.push_back(b);
    wait_in(20, "mask_a");
    enables = 4'b0011;
    b.d = 64'h2223_2222_2221_2220; b.l = 1; in_q.push_back(b);
    wait_in(20, "mask_b");
    rmode = 0;
    wait_out(2, 20, "mask_f1");
    b.d = 64'h0003_0002_0001_0000; b.l = 1; in_q.push_back(b);
    wait_out(4, 30, "mask_f2");
    if (out_q.size() >= 4) begin
      chk("mask_f1_d0", out_q[0].d, 64'h1113_1112_1111_1110);
      chk("mask_f1_d1", out_q[1].d, 64'h2223_2222_2221_2220);
      chk("mask_f1_en", 64'({out_q[0].en, out_q[1].en}), 64'h0ff);
      chk("mask_f1_last", 64'({out_q[0].l, out_q[1].l}), 64'd1);
      chk("mask_f2_d0", out_q[2].d, 64'h0000_0000_0001_0000);
      chk("mask_f2_d1", out_q[3].d, 64'h0000_0000_0003_0002);
      chk("mask_f2_en", 64'({out_q[2].en, out_q[3].en}), 64'h033);
      chk("mask_f2_last", 64'({out_q[2].l, out_q[3].l}), 64'd1);
    end

    // Reset with six samples buffered.
    do_reset();
    enables = 4'b0011; m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 64'h4443_4442_4441_4440; s_tlast = 1'b0;
    @(posedge clk); #1;
    s_tvalid = 1'b0; m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 64'h5553_5552_5551_5550;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    chk("cnt6_tready", 64'(s_tready), 64'd0);
    chk("cnt6_tvalid", 64'(m_tvalid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_tready", 64'(s_tready), 64'd1);

    // No lanes enabled: beats are swallowed.
    do_reset();
    enables = 4'b0000; m_tready = 1'b1;
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = {32'(i), 32'hdead}; s_tlast = (i == 2);
      chk($sformatf("drop_ready%0d", i), 64'(s_tready), 64'd1);
      @(posedge clk); #1;
      if (m_tvalid) quiet++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (m_tvalid || !s_tready) quiet++;
    end
    chk("drop_no_output", 64'(quiet), 64'd0);

`ifdef RWT_SAMPLE_UNPACK_UNDERFLOW_EN
    do_reset();
    enables = 4'b1111; m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 64'h0003_0002_0001_0000; s_tlast = 1'b0;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    chk("uf_first_valid", 64'(m_tvalid), 64'd1);
    @(posedge clk); #1;
    chk("uf_zero", 64'(uf), 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("uf_ten", 64'(uf), 64'd10);
`endif

    rand_run(4'b1000, 1000, 1, 20, 40000);
    for (int r = 0; r < 3; r++)
      rand_run(4'($urandom_range(1, 15)), 150, 2, 30, 8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rwt_sample_unpack.md
Name: rwt_sample_unpack

Overview:
- Inverse of the sample packer. Consumes a packed 64-bit AXI-Stream of 16-bit samples (4 per beat, contiguous, ascending order).
- Re-distributes the samples onto the enabled lanes of a 4-lane x 16-bit output stream; disabled lanes read zero.
- Sits on the transmit path between the DMA/packed domain and per-channel consumers, for example the DAC interface.

Parameters:
- DWIDTH, 64, stream data width; fixed at 4 lanes x SWIDTH.
- SWIDTH, 16, sample width.
- LANES, 4, channel count. Equals DWIDTH/SWIDTH and is checked at elaboration.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enables  in  4  requested channel mask; bit i = lane i
- s_axi_tdata  in  64  packed samples; sample k = bits [16k+15:16k]
- s_axi_tvalid  in  1  input valid
- s_axi_tready  out  1  input ready
- s_axi_tlast  in  1  end of frame
- m_axi_tdata  out  64  lane i = bits [16i+15:16i]
- m_axi_tvalid  out  1  output valid
- m_axi_tready  in  1  output ready
- m_axi_tlast  out  1  end of frame
- m_axi_enables  out  4  mask in effect for the current output beat

Behaviour:
- Buffer: 8-sample register file plus count (0..8). Samples are consumed oldest first.
- active_en: a register. Loads from enables on every cycle where count==0 and last_pend==0; otherwise it holds. N = popcount(active_en).
- Reset: count=0, last_pend=0, active_en=0, m_axi_tvalid=0, m_axi_tlast=0, m_axi_tdata=0, m_axi_enables=0. A reset mid-frame discards all buffered samples.
- s_axi_tready = (count<=4) && !last_pend. It is registered-state only, with no combinational path from m_axi_tready.
- Input accept (tvalid && tready): the 4 samples are appended at positions count..count+3. If tlast=1, last_pend is set and last_cnt = count+4.
- m_axi_tvalid = (N>0) && (count>=N || (last_pend && count>0)).
- Output lane mapping: the j-th oldest buffered sample goes to the j-th set bit of active_en, scanning ascending lane index. Unmapped lanes are 0.
- Flush beat: when last_pend and count<N, only count samples are placed; the remaining enabled lanes are zero-filled.
- m_axi_tlast = last_pend && (count<=N), i.e. this beat consumes the final frame sample.
- Output fire: removes min(N,count) samples and shifts the buffer. When m_axi_tlast fires, count becomes 0 and last_pend is cleared.
- Simultaneous accept and fire: count_next = count + 4 - consumed. Never exceeds 8, because accept requires count<=4.
- Latency: an input accepted on cycle t can produce m_axi_tvalid on cycle t+1. Output data is a combinational function of registers only.
- Throughput: N=4 gives 1 beat/cycle sustained. N<4 gives 4/N output beats per input beat, with the input stalled accordingly.
- active_en==0: input beats are accepted and dropped (count stays 0), and no output is produced.
- Stability: m_axi_tdata, m_axi_tlast and m_axi_enables hold stable while m_axi_tvalid && !m_axi_tready.
- Mask changes: enables changes mid-frame are ignored until the buffer drains at the frame boundary.

Optional Feature:
- Macro: RWT_SAMPLE_UNPACK_UNDERFLOW_EN.
- When defined: adds output port underflow_count (out, 32). It is a saturating counter of cycles with m_axi_tready=1, m_axi_tvalid=0, active_en!=0, after the first output beat since reset. Reset value is 0.
- When undefined: the port and logic are absent.

Decomposition:
- Package rwt_sample_pkg: SWIDTH/LANES constants, a sample_t typedef (logic [15:0]), a popcount4 function, and an nth_set_lane function (returns the lane index of the j-th set bit).
- One sub-module, rwt_lane_scatter: purely combinational. Takes 4 ordered samples, a valid count and a mask, and produces the 64-bit lane word. It is reused later by the packer verification model.

Test Plan:
1. enables=4'b1111; beats 0x0003_0002_0001_0000, 0x0007_0006_0005_0004 with tlast on the 2nd -> output identical beats, tlast on the 2nd, 1 beat/cycle with m_axi_tready held high.
2. enables=4'b0101; one beat 0x0003_0002_0001_0000 with tlast -> out 0x0000_0001_0000_0000 then 0x0000_0003_0000_0002 (tlast), m_axi_enables=4'b0101.
3. enables=4'b0111; beats 0..3 and 4..7 (samples 0-7), tlast on the 2nd -> out lanes{0,1,2} = {0,1,2},{3,4,5},{6,7,0}, tlast on the 3rd (flush zero-fill).
4. enables=4'b1000, m_axi_tready throttled 1-in-5 -> each input beat gives 4 outputs with the sample in lane 3, s_axi_tready low while count>4, no data loss or reorder over 1000 random beats vs the scoreboard.
5. Mid-frame enables change 4'b1111->4'b0011 -> current frame still uses 4'b1111; the next frame uses 4'b0011. Reset pulsed with count=6 -> next cycle m_axi_tvalid=0 and s_axi_tready=1.
6. enables=0 with 3 input beats -> all accepted, no output. With RWT_SAMPLE_UNPACK_UNDERFLOW_EN, stall input 10 cycles after the first output with m_axi_tready=1 -> underflow_count=10.
